// File: rtl/ibus_fetch_bridge.sv
// ============================================================================
// ibus_fetch_bridge : single-outstanding instruction-bus fetch bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module ibus_fetch_bridge #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        flush,
  input  logic        stall_downstream,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [31:0] raw_instr,
  output logic        instr_valid,
  output logic        exc_adel,
  output logic        fetch_stall
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DISCARD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        exc_q, exc_d;
  logic        drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (pc_valid && !flush) begin
          if (pc[1:0] == 2'b00) begin
            state_d = S_REQ;
            addr_d  = pc;
          end else begin
            state_d = S_DONE;
            instr_d = NOP;
            exc_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        // The request is never withdrawn; a flush only marks its response for dropping.
        if (ireq_addr_ok) begin
          state_d = (drop_q || flush) ? S_DISCARD : S_WAIT;
          drop_d  = drop_q || flush;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = iresp_data_ok ? S_IDLE : S_DISCARD;
        end else if (iresp_data_ok) begin
          state_d = S_DONE;
          instr_d = iresp_data;
          exc_d   = 1'b0;
        end
      end
      S_DISCARD: begin
        if (iresp_data_ok) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (flush || !stall_downstream) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0000_0000;
      instr_q <= NOP;
      exc_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      drop_q  <= drop_d;
    end
  end

  assign ireq_valid  = (state_q == S_REQ);
  assign ireq_addr   = addr_q;
  assign instr_valid = (state_q == S_DONE);
  assign raw_instr   = instr_valid ? instr_q : NOP;
  assign exc_adel    = instr_valid && exc_q;
  assign fetch_stall = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (state_q == S_DISCARD) || ((state_q == S_IDLE) && pc_valid);

endmodule

`default_nettype wire

// File: tb/tb_ibus_fetch_bridge.sv
// ============================================================================
// tb_ibus_fetch_bridge : scoreboard bench for ibus_fetch_bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ibus_fetch_bridge;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall_downstream = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic [31:0] raw_instr;
  logic        instr_valid;
  logic        exc_adel;
  logic        fetch_stall;

  int checks = 0;
  int errors = 0;

  // Expected fetch results {exc_adel, raw_instr}, in presentation order
  logic [32:0] exp_q[$];
  logic [32:0] cur = '0;
  logic        iv_prev = 1'b0;

  ibus_fetch_bridge #(.NOP(NOP)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .flush            (flush),
    .stall_downstream (stall_downstream),
    .ireq_valid       (ireq_valid),
    .ireq_addr        (ireq_addr),
    .ireq_addr_ok     (ireq_addr_ok),
    .iresp_data_ok    (iresp_data_ok),
    .iresp_data       (iresp_data),
    .raw_instr        (raw_instr),
    .instr_valid      (instr_valid),
    .exc_adel         (exc_adel),
    .fetch_stall      (fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on each new presentation, then require hold / NOP otherwise
  always @(negedge clk) begin
    if (!resetn) begin
      iv_prev = 1'b0;
    end else begin
      if (instr_valid && !iv_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got instr %h with nothing expected at %0t", raw_instr, $time);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_instr", raw_instr, cur[31:0]);
          chk("sb_exc", {31'd0, exc_adel}, {31'd0, cur[32]});
        end
      end else if (instr_valid) begin
        chk("hold_instr", raw_instr, cur[31:0]);
        chk("hold_exc", {31'd0, exc_adel}, {31'd0, cur[32]});
      end else begin
        chk("nop_idle", raw_instr, NOP);
      end
      iv_prev = instr_valid;
    end
  end

  // One fetch: addr_ok after dly wait cycles, data_ok after d2 wait cycles,
  // optional flush in REQ (index fi) / WAIT (index fw), ns stall cycles in DONE,
  // fd = leave DONE through a flush.
  task automatic txn(input logic [31:0] p, input logic [31:0] d, input int dly,
                     input bit flreq, input int fi, input int d2, input bit flw,
                     input int fw, input int ns, input bit fd);
    bit dropped;
    dropped = 1'b0;
    pc = p; pc_valid = 1'b1; flush = 1'b0; stall_downstream = 1'b0;
    #1 chk("stall_idle_pcv", {31'd0, fetch_stall}, 32'd1);
    if (p[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, NOP});
      cyc();
      chk("adel_no_req", {31'd0, ireq_valid}, 32'd0);
      chk("adel_iv", {31'd0, instr_valid}, 32'd1);
    end else begin
      cyc();
      for (int i = 0; i <= dly; i++) begin
        pc = $urandom; pc_valid = 1'($urandom_range(0, 1));
        chk("req_valid", {31'd0, ireq_valid}, 32'd1);
        chk("req_addr", ireq_addr, p);
        chk("req_stall", {31'd0, fetch_stall}, 32'd1);
        ireq_addr_ok = (i == dly);
        flush = flreq && (i == fi);
        cyc();
      end
      ireq_addr_ok = 1'b0; flush = 1'b0;
      dropped = flreq || flw;
      for (int j = 0; j <= d2; j++) begin
        chk("wait_no_req", {31'd0, ireq_valid}, 32'd0);
        chk("wait_no_iv", {31'd0, instr_valid}, 32'd0);
        chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
        iresp_data_ok = (j == d2);
        iresp_data = (j == d2) ? d : $urandom;
        flush = flw && (j == fw);
        if (j == d2 && !dropped) exp_q.push_back({1'b0, d});
        cyc();
      end
      iresp_data_ok = 1'b0; flush = 1'b0;
      if (!dropped) chk("latency_iv", {31'd0, instr_valid}, 32'd1);
    end
    if (!dropped) begin
      for (int k = 0; k < ns; k++) begin
        chk("done_iv", {31'd0, instr_valid}, 32'd1);
        chk("done_stall", {31'd0, fetch_stall}, 32'd0);
        stall_downstream = 1'b1;
        cyc();
      end
      chk("done_iv_last", {31'd0, instr_valid}, 32'd1);
      stall_downstream = fd ? 1'b1 : 1'b0;
      flush = fd;
      cyc();
      stall_downstream = 1'b0; flush = 1'b0;
    end
    pc_valid = 1'b0;
    #1;
    chk("end_iv", {31'd0, instr_valid}, 32'd0);
    chk("end_req", {31'd0, ireq_valid}, 32'd0);
    chk("end_stall", {31'd0, fetch_stall}, 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", {31'd0, ireq_valid}, 32'd0);
    chk("rst_req_addr", ireq_addr, 32'd0);
    chk("rst_raw_instr", raw_instr, NOP);
    chk("rst_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_exc", {31'd0, exc_adel}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outputs();
    cyc();
    resetn = 1'b1;
    cyc();

    txn(32'hBFC0_0000, 32'h2408_0001, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(32'hBFC0_0000, 32'h1234_5678, 3, 0, 0, 1, 0, 0, 0, 0);
    txn(32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0, 2, 1, 0, 0, 0);
    txn(32'h0000_0200, 32'hCAFE_0001, 1, 0, 0, 0, 0, 0, 0, 0);
    txn(32'h0000_0002, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(32'h0000_0300, 32'hA5A5_5A5A, 0, 0, 0, 0, 0, 0, 3, 1);
    txn(32'h0000_0400, 32'h1111_2222, 2, 1, 1, 1, 0, 0, 0, 0);
    txn(32'h0000_0500, 32'h3333_4444, 1, 1, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] p;
      int dly, d2;
      p = $urandom;
      if ($urandom_range(0, 4) != 0) p[1:0] = 2'b00;
      else if (p[1:0] == 2'b00) p[1:0] = 2'b10;
      dly = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      txn(p, $urandom, dly, $urandom_range(0, 4) == 0, $urandom_range(0, dly),
          d2, $urandom_range(0, 4) == 0, $urandom_range(0, d2),
          $urandom_range(0, 3), $urandom_range(0, 2) == 0);
    end

    // Reset while WAIT holds an accepted request
    pc = 32'h0000_1000; pc_valid = 1'b1;
    cyc();
    pc_valid = 1'b0; ireq_addr_ok = 1'b1;
    cyc();
    ireq_addr_ok = 1'b0;
    chk("pre_rst_wait_stall", {31'd0, fetch_stall}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs();
    cyc();
    resetn = 1'b1;
    txn(32'h0000_2000, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 1, 0);

    cyc(); cyc();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ibus_fetch_bridge.md
IBUS_FETCH_BRIDGE -- requirements
Module: ibus_fetch_bridge

Interface
REQ-001 Parameter NOP, 32'h0000_0000, value SHALL be driven on raw_instr when no instruction is held.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 pc  in  32  fetch PC from freg.
REQ-005 pc_valid  in  1  pc holds an instruction to fetch.
REQ-006 flush  in  1  redirect; in-flight fetch SHALL be discarded.
REQ-007 stall_downstream  in  1  fetch stage held by later stage.
REQ-008 ireq_valid  out  1  instruction bus request.
REQ-009 ireq_addr  out  32  request word address.
REQ-010 ireq_addr_ok  in  1  request accepted this cycle.
REQ-011 iresp_data_ok  in  1  response data valid this cycle.
REQ-012 iresp_data  in  32  response instruction word.
REQ-013 raw_instr  out  32  fetched instruction to fetch stage.
REQ-014 instr_valid  out  1  raw_instr is valid.
REQ-015 exc_adel  out  1  misaligned-PC fetch exception, qualified by instr_valid.
REQ-016 fetch_stall  out  1  fetch waiting on bus.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DISCARD, DONE.
REQ-018 IDLE: pc_valid, pc[1:0]==0, !flush -> REQ; ireq_addr SHALL latch pc.
REQ-019 IDLE: pc_valid, pc[1:0]!=0, !flush -> DONE, exc_adel=1, raw_instr=NOP, no bus request issued.
REQ-020 ireq_valid SHALL be 1 exactly while in REQ; ireq_addr SHALL stay stable in REQ until ireq_addr_ok.
REQ-021 REQ: ireq_addr_ok -> WAIT, or -> DISCARD if drop flag set or flush this cycle.
REQ-022 REQ: flush without ireq_addr_ok SHALL set drop flag and stay REQ; the request SHALL NOT be withdrawn.
REQ-023 pc_valid or pc changes after leaving IDLE SHALL be ignored until the next IDLE.
REQ-024 WAIT: iresp_data_ok, !flush -> DONE, raw_instr<=iresp_data, exc_adel<=0.
REQ-025 WAIT: flush (with or without iresp_data_ok) -> DISCARD, or -> IDLE if iresp_data_ok same cycle; data dropped.
REQ-026 DISCARD: iresp_data_ok -> IDLE, data dropped, drop flag cleared; instr_valid stays 0.
REQ-027 DONE: instr_valid=1; !stall_downstream -> IDLE; stall_downstream -> stay DONE, raw_instr/exc_adel held.
REQ-028 DONE: flush SHALL win over stall_downstream -> IDLE, instr_valid 0 next cycle.
REQ-029 instr_valid SHALL be 1 only in DONE; raw_instr SHALL be NOP whenever not in DONE.
REQ-030 fetch_stall SHALL be 1 in REQ, WAIT, DISCARD, and in IDLE when pc_valid; 0 in DONE and idle without pc_valid.
REQ-031 Minimum latency: pc_valid at cycle 0, addr_ok cycle 1, data_ok cycle 2 -> instr_valid cycle 3.
REQ-032 Exactly one iresp_data_ok SHALL be consumed per accepted request; at most one request outstanding.

Reset
REQ-033 resetn low SHALL immediately force IDLE, ireq_valid=0, ireq_addr=0, raw_instr=NOP, instr_valid=0, exc_adel=0, drop flag=0.
REQ-034 Reset mid-transaction SHALL abandon the request; the bus is reset together, no late iresp_data_ok is expected.
REQ-035 First request after resetn rises SHALL follow REQ-018 at the first edge with pc_valid.

Verification
REQ-036 pc=0xBFC0_0000 valid, addr_ok c1, data_ok c2 data 0x2408_0001 -> ireq_addr=0xBFC0_0000, instr_valid c3, raw_instr=0x2408_0001.
REQ-037 addr_ok delayed 3 cycles, pc changed to 0x10 meanwhile -> ireq_valid high 4 cycles, ireq_addr stays 0xBFC0_0000.
REQ-038 flush in WAIT, data_ok 2 cycles later data 0xDEAD_BEEF -> instr_valid never 1, return to IDLE, next request issued for new pc.
REQ-039 pc=0x0000_0002 valid -> no ireq_valid, next cycle instr_valid=1, exc_adel=1, raw_instr=NOP.
REQ-040 DONE with stall_downstream high 3 cycles then flush -> raw_instr held 3 cycles, instr_valid 0 after flush.
REQ-041 resetn low while in WAIT -> all outputs reset values immediately, ireq_valid 0.
